// File: rtl/sand_pkg.sv
// Shared cell encoding and controller state encoding for the sand update engine.
package sand_pkg;

    localparam int unsigned CELL_CODE_EMPTY = 0;
    localparam int unsigned CELL_CODE_SAND  = 1;
    localparam int unsigned CELL_CODE_WALL  = 2;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_SAND  = 2'd1,
        CELL_WALL  = 2'd2
    } cell_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD_SELF   = 4'd1,
        ST_CHK_SELF  = 4'd2,
        ST_CHK_BELOW = 4'd3,
        ST_CHK_D1    = 4'd4,
        ST_CHK_D2    = 4'd5,
        ST_WR_DST    = 4'd6,
        ST_WR_SRC    = 4'd7,
        ST_NEXT      = 4'd8,
        ST_DONE      = 4'd9
    } state_t;

endpackage

// File: rtl/sand_scan_counter.sv
// Bottom-up raster scan position (x, y) and linear cell address, kept in step
// incrementally so no multiplier is needed.
module sand_scan_counter #(
    parameter int ADDR_WIDTH = 19,
    parameter int COLS       = 640,
    parameter int ROWS       = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 9
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  adv_i,
    output logic [X_W-1:0]        x_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [X_W-1:0]        X_LAST     = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]        Y_FIRST    = Y_W'(ROWS - 2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'((ROWS - 2) * COLS);
    // From the last cell of row y back to the first cell of row y-1.
    localparam logic [ADDR_WIDTH-1:0] ROW_BACK   = ADDR_WIDTH'(2 * COLS - 1);

    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = Y_FIRST;
            addr_d = ADDR_FIRST;
        end else if (adv_i) begin
            if (x_q == X_LAST) begin
                x_d    = '0;
                y_d    = y_q - Y_W'(1);
                addr_d = addr_q - ROW_BACK;
            end else begin
                x_d    = x_q + X_W'(1);
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x_q;
    assign addr_o = addr_q;
    assign last_o = (x_q == X_LAST) && (y_q == '0);

endmodule

// File: rtl/sand_update_engine.sv
// Falling-sand step engine: walks the grid bottom-up, moving each grain down
// (or diagonally) into empty space through a one-read/one-write cell RAM.
module sand_update_engine #(
    parameter int VRAM_ADDR_WIDTH = 19,
    parameter int CELL_WIDTH      = 2,
    parameter int ACTIVE_COLUMNS  = 640,
    parameter int ACTIVE_ROWS     = 480,
    parameter int DIAG_EN         = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [VRAM_ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [CELL_WIDTH-1:0]      rd_data_i,
    output logic                       wr_en_o,
    output logic [VRAM_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [CELL_WIDTH-1:0]      wr_data_o
);

    import sand_pkg::*;

    localparam int AW  = VRAM_ADDR_WIDTH;
    localparam int X_W = (ACTIVE_COLUMNS > 1) ? $clog2(ACTIVE_COLUMNS) : 1;
    localparam int Y_W = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
    localparam logic [AW-1:0]  COLS_A = AW'(ACTIVE_COLUMNS);
    localparam logic [X_W-1:0] X_LAST = X_W'(ACTIVE_COLUMNS - 1);

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [AW-1:0]   dst_q, dst_d;

    logic            scan_clear, scan_adv, scan_last;
    logic [X_W-1:0]  scan_x;
    logic [AW-1:0]   scan_addr;

    sand_scan_counter #(
        .ADDR_WIDTH (AW),
        .COLS       (ACTIVE_COLUMNS),
        .ROWS       (ACTIVE_ROWS),
        .X_W        (X_W),
        .Y_W        (Y_W)
    ) u_scan (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (scan_clear),
        .adv_i   (scan_adv),
        .x_o     (scan_x),
        .addr_o  (scan_addr),
        .last_o  (scan_last)
    );

    cell_t rd_cell;

    always_comb begin
        rd_cell = CELL_WALL;
        if (rd_data_i == CELL_WIDTH'(CELL_CODE_EMPTY)) begin
            rd_cell = CELL_EMPTY;
        end else if (rd_data_i == CELL_WIDTH'(CELL_CODE_SAND)) begin
            rd_cell = CELL_SAND;
        end
    end

    // Diagonal candidates; d1 is the preferred side chosen by dir_q.
    logic [AW-1:0] below_addr, left_addr, right_addr, d1_addr, d2_addr;
    logic          left_ok, right_ok, d1_ok, d2_ok;

    assign below_addr = scan_addr + COLS_A;
    assign left_addr  = below_addr - AW'(1);
    assign right_addr = below_addr + AW'(1);
    assign left_ok    = (scan_x != '0);
    assign right_ok   = (scan_x != X_LAST);
    assign d1_ok      = dir_q ? right_ok : left_ok;
    assign d2_ok      = dir_q ? left_ok : right_ok;
    assign d1_addr    = dir_q ? right_addr : left_addr;
    assign d2_addr    = dir_q ? left_addr : right_addr;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dst_d      = dst_q;
        scan_clear = 1'b0;
        scan_adv   = 1'b0;
        rd_addr_o  = '0;
        wr_en_o    = 1'b0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    scan_clear = 1'b1;
                    state_d    = ST_RD_SELF;
                end
            end
            ST_RD_SELF: begin
                rd_addr_o = scan_addr;
                state_d   = ST_CHK_SELF;
            end
            ST_CHK_SELF: begin
                if (rd_cell == CELL_SAND) begin
                    rd_addr_o = below_addr;
                    state_d   = ST_CHK_BELOW;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_CHK_BELOW: begin
                if (rd_cell == CELL_EMPTY) begin
                    dst_d   = below_addr;
                    state_d = ST_WR_DST;
                end else if (DIAG_EN != 0) begin
                    if (d1_ok) begin
                        rd_addr_o = d1_addr;
                    end
                    state_d = ST_CHK_D1;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_CHK_D1: begin
                if (d1_ok && (rd_cell == CELL_EMPTY)) begin
                    dst_d   = d1_addr;
                    dir_d   = ~dir_q;
                    state_d = ST_WR_DST;
                end else begin
                    if (d2_ok) begin
                        rd_addr_o = d2_addr;
                    end
                    state_d = ST_CHK_D2;
                end
            end
            ST_CHK_D2: begin
                if (d2_ok && (rd_cell == CELL_EMPTY)) begin
                    dst_d   = d2_addr;
                    dir_d   = ~dir_q;
                    state_d = ST_WR_DST;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_WR_DST: begin
                wr_en_o   = 1'b1;
                wr_addr_o = dst_q;
                wr_data_o = CELL_WIDTH'(CELL_CODE_SAND);
                state_d   = ST_WR_SRC;
            end
            ST_WR_SRC: begin
                wr_en_o   = 1'b1;
                wr_addr_o = scan_addr;
                wr_data_o = CELL_WIDTH'(CELL_CODE_EMPTY);
                state_d   = ST_NEXT;
            end
            ST_NEXT: begin
                if (scan_last) begin
                    state_d = ST_DONE;
                end else begin
                    scan_adv = 1'b1;
                    state_d  = ST_RD_SELF;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A reset landing between WR_DST and WR_SRC leaves the source grain in place.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dst_q   <= dst_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

endmodule
